// File: rtl/pmem_burst_adapter.sv
// Cache-line to memory-burst adapter: turns one 256-bit line read/write into a
// 4-beat 64-bit burst and returns a single-cycle line response upstream.
module pmem_burst_adapter #(
  parameter int BEATS      = 4,
  parameter int BEAT_WIDTH = 64,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  line_read,
  input  logic                  line_write,
  input  logic [31:0]           line_address,
  input  logic [LINE_WIDTH-1:0] line_wdata,
  output logic [LINE_WIDTH-1:0] line_rdata,
  output logic                  line_resp,
  output logic                  burst_read,
  output logic                  burst_write,
  output logic [31:0]           burst_address,
  output logic [BEAT_WIDTH-1:0] burst_wdata,
  input  logic [BEAT_WIDTH-1:0] burst_rdata,
  input  logic                  burst_resp
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [LINE_WIDTH-1:0] wdata_r;

  function automatic logic [BEAT_WIDTH-1:0] beat_of(input logic [LINE_WIDTH-1:0] line,
                                                     input logic [CNT_W-1:0] idx);
    beat_of = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (idx == CNT_W'(i)) begin
        beat_of = line[i*BEAT_WIDTH +: BEAT_WIDTH];
      end
    end
  endfunction

  // Burst sequencer; every output is a register so nothing upstream leaks straight to memory.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      wdata_r       <= '0;
      line_rdata    <= '0;
      line_resp     <= 1'b0;
      burst_read    <= 1'b0;
      burst_write   <= 1'b0;
      burst_address <= 32'h0000_0000;
      burst_wdata   <= '0;
    end else begin
      line_resp <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          // Read has priority; a held write is picked up after the read completes.
          if (line_read) begin
            state_r       <= READ;
            burst_read    <= 1'b1;
            burst_address <= {line_address[31:5], 5'b00000};
          end else if (line_write) begin
            state_r       <= WRITE;
            burst_write   <= 1'b1;
            burst_address <= {line_address[31:5], 5'b00000};
            wdata_r       <= line_wdata;
            burst_wdata   <= line_wdata[BEAT_WIDTH-1:0];
          end else begin
            state_r <= IDLE;
          end
        end
        READ: begin
          if (burst_resp) begin
            for (int i = 0; i < BEATS; i++) begin
              if (cnt_r == CNT_W'(i)) begin
                line_rdata[i*BEAT_WIDTH +: BEAT_WIDTH] <= burst_rdata;
              end
            end
            if (cnt_r == LAST_BEAT) begin
              state_r    <= DONE;
              burst_read <= 1'b0;
              line_resp  <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        WRITE: begin
          if (burst_resp) begin
            if (cnt_r == LAST_BEAT) begin
              state_r     <= DONE;
              burst_write <= 1'b0;
              line_resp   <= 1'b1;
            end else begin
              cnt_r       <= cnt_r + CNT_W'(1);
              burst_wdata <= beat_of(wdata_r, cnt_r + CNT_W'(1));
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= '0;
          burst_read  <= 1'b0;
          burst_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_burst_adapter.sv
// Directed bench for pmem_burst_adapter: inputs change and outputs are sampled
// on the falling edge, so each step below is one clock cycle.
module tb_pmem_burst_adapter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         line_read;
  logic         line_write;
  logic [31:0]  line_address;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic         burst_read;
  logic         burst_write;
  logic [31:0]  burst_address;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  int checks   = 0;
  int failures = 0;

  logic [255:0] wline;
  logic [63:0]  wbeat [4];
  int           widx;
  bit           pat [7];

  always #5 clk = ~clk;

  pmem_burst_adapter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .line_read    (line_read),
    .line_write   (line_write),
    .line_address (line_address),
    .line_wdata   (line_wdata),
    .line_rdata   (line_rdata),
    .line_resp    (line_resp),
    .burst_read   (burst_read),
    .burst_write  (burst_write),
    .burst_address(burst_address),
    .burst_wdata  (burst_wdata),
    .burst_rdata  (burst_rdata),
    .burst_resp   (burst_resp)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mk_line(input logic [63:0] base);
    return {base + 64'd3, base + 64'd2, base + 64'd1, base};
  endfunction

  // Called on the falling edge of cycle 1 of a read; ends on the falling edge of the line_resp cycle.
  task automatic read_zero_wait(input logic [63:0] base, input logic [31:0] aexp, input bit drop);
    for (int i = 0; i < 4; i++) begin
      if (drop && i == 1) line_read = 1'b0;
      chk("rd_busy", burst_read, 1'b1);
      chk("rd_nowr", burst_write, 1'b0);
      chk("rd_addr", burst_address, aexp);
      chk("rd_noresp", line_resp, 1'b0);
      burst_resp  = 1'b1;
      burst_rdata = base + 64'(i);
      tick();
    end
    burst_resp = 1'b0;
    chk("rd_resp", line_resp, 1'b1);
    chk("rd_done_drop", burst_read, 1'b0);
    chk("rd_line", line_rdata, mk_line(base));
  endtask

  initial begin
    rst_n = 1'b0; line_read = 1'b0; line_write = 1'b0;
    line_address = 32'h0; line_wdata = 256'h0;
    burst_rdata = 64'h0; burst_resp = 1'b0;
    tick(); tick();
    chk("rst_resp", line_resp, 1'b0);
    chk("rst_rd", burst_read, 1'b0);
    chk("rst_wr", burst_write, 1'b0);
    chk("rst_addr", burst_address, 32'h0);
    chk("rst_wdata", burst_wdata, 64'h0);
    chk("rst_rdata", line_rdata, 256'h0);
    rst_n = 1'b1;
    tick();

    // 1: zero-wait read
    line_read = 1'b1; line_address = 32'h0000_1234;
    tick();
    read_zero_wait(64'hA0, 32'h0000_1220, 1'b0);
    chk("t1_lo", line_rdata[63:0], 64'hA0);
    chk("t1_hi", line_rdata[255:192], 64'hA3);
    line_read = 1'b0;
    tick();
    chk("t1_single_resp", line_resp, 1'b0);

    // 2: write with alternating stalls; inputs change mid-burst and must be ignored
    for (int i = 0; i < 4; i++) begin
      wbeat[i] = 64'h1111_1111_1111_1111 * 64'(i + 1);
      wline[i*64 +: 64] = wbeat[i];
    end
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    line_write = 1'b1; line_address = 32'h0000_ABCD; line_wdata = wline;
    tick();
    widx = 0;
    for (int c = 0; c < 7; c++) begin
      if (c == 2) begin
        line_wdata = ~wline; line_address = 32'hFFFF_FFFF;
      end
      chk("t2_wr", burst_write, 1'b1);
      chk("t2_wdata", burst_wdata, wbeat[widx]);
      chk("t2_addr", burst_address, 32'h0000_ABC0);
      chk("t2_noresp", line_resp, 1'b0);
      burst_resp = pat[c];
      tick();
      if (pat[c]) widx++;
    end
    burst_resp = 1'b0;
    chk("t2_resp", line_resp, 1'b1);
    chk("t2_wr_drop", burst_write, 1'b0);
    chk("t2_rdata_kept", line_rdata, mk_line(64'hA0));
    line_write = 1'b0;
    tick();

    // 3: read and write both held; read first, write two cycles after line_resp
    line_read = 1'b1; line_write = 1'b1; line_address = 32'h0000_0100;
    line_wdata = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
    tick();
    read_zero_wait(64'hB0, 32'h0000_0100, 1'b0);
    chk("t3_no_wr_yet", burst_write, 1'b0);
    line_read = 1'b0;
    tick();
    chk("t3_gap_rd", burst_read, 1'b0);
    chk("t3_gap_wr", burst_write, 1'b0);
    chk("t3_gap_resp", line_resp, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t3_wr", burst_write, 1'b1);
      chk("t3_no_rd", burst_read, 1'b0);
      chk("t3_wdata", burst_wdata, 64'hD0 + 64'(i));
      burst_resp = 1'b1;
      tick();
    end
    burst_resp = 1'b0;
    chk("t3_wresp", line_resp, 1'b1);
    chk("t3_rdata_kept", line_rdata, mk_line(64'hB0));
    line_write = 1'b0;
    tick();

    // 4: request dropped after first beat
    line_read = 1'b1; line_address = 32'h0000_0200;
    tick();
    read_zero_wait(64'hC0, 32'h0000_0200, 1'b1);
    tick();
    chk("t4_single_resp", line_resp, 1'b0);
    tick();
    chk("t4_no_restart", burst_read, 1'b0);
    chk("t4_no_resp2", line_resp, 1'b0);

    // 5: reset after two read beats
    line_read = 1'b1; line_address = 32'h0000_0300;
    tick();
    for (int i = 0; i < 2; i++) begin
      burst_resp = 1'b1; burst_rdata = 64'hE0 + 64'(i);
      tick();
    end
    burst_resp = 1'b0; rst_n = 1'b0; line_read = 1'b0;
    tick();
    chk("t5_rd", burst_read, 1'b0);
    chk("t5_rdata", line_rdata, 256'h0);
    chk("t5_resp", line_resp, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("t5_resp2", line_resp, 1'b0);
    line_read = 1'b1; line_address = 32'h0000_0340;
    tick();
    read_zero_wait(64'hF0, 32'h0000_0340, 1'b0);
    line_read = 1'b0;
    tick();

    // 6: back-to-back reads, re-request the cycle after line_resp
    line_read = 1'b1; line_address = 32'h0000_0040;
    tick();
    read_zero_wait(64'h10, 32'h0000_0040, 1'b0);
    line_read = 1'b0;
    tick();
    chk("t6_addr_hold", burst_address, 32'h0000_0040);
    line_read = 1'b1; line_address = 32'h0000_0060;
    tick();
    read_zero_wait(64'h20, 32'h0000_0060, 1'b0);
    line_read = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pmem_burst_adapter.md
Name: pmem_burst_adapter

Overview:
Sits directly downstream of the cache hierarchy's physical-memory port, after the L2 write-evict buffer. It converts each 256-bit cache-line read or write into a 4-beat, 64-bit burst on the off-chip memory interface. It assembles read beats into a full line, slices write lines into beats, and returns a single-cycle line response upstream.

Parameters:
BEATS, 4, beats per cache line.
BEAT_WIDTH, 64, data bits per beat.
LINE_WIDTH, 256, cache-line bits. Must equal BEATS*BEAT_WIDTH.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
line_read  input  1  line read request from L2 write-evict buffer; held until line_resp
line_write  input  1  line write request; held until line_resp
line_address  input  32  line address; bits [4:0] ignored
line_wdata  input  LINE_WIDTH  write line; beat i = bits [64i+63:64i]
line_rdata  output  LINE_WIDTH  assembled read line
line_resp  output  1  one-cycle completion pulse
burst_read  output  1  burst read request to memory
burst_write  output  1  burst write request to memory
burst_address  output  32  {line_address[31:5],5'b0}, stable for the whole burst
burst_wdata  output  BEAT_WIDTH  current write beat
burst_rdata  input  BEAT_WIDTH  current read beat
burst_resp  input  1  per-beat acknowledge; one beat transfers per cycle it is high

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- FSM states: IDLE, READ, WRITE, DONE.
- Reset values: state=IDLE, beat counter=0, line_resp=0, burst_read=0, burst_write=0, burst_address=0, burst_wdata=0, line_rdata=0.
- All outputs are registered or decoded from state (Moore). No input-to-output combinational path.
- IDLE:
  - line_read=1: latch address, counter=0, go to READ.
  - line_write=1: latch address and line_wdata, counter=0, go to WRITE.
  - Both high: read wins. The write is serviced afterwards if still held.
  - burst_resp is ignored in IDLE.
- READ:
  - burst_read=1 for every cycle in READ.
  - Each cycle with burst_resp=1: store burst_rdata into line_rdata beat[counter], counter++.
  - When the beat at counter=BEATS-1 is accepted: go to DONE. burst_read drops in DONE.
- WRITE:
  - burst_write=1.
  - burst_wdata = latched beat[counter].
  - On burst_resp: counter++. Last beat accepted: go to DONE.
- DONE:
  - line_resp=1 for exactly one cycle, then go to IDLE.
  - Upstream drops its request on the same edge, so the next request is sampled in IDLE one cycle later at the earliest.
- Latency:
  - Request sampled at edge 0; burst_read/burst_write high from cycle 1.
  - Zero-wait memory (burst_resp high on the first request cycle): beats in cycles 1–4, line_resp in cycle 5.
  - Each stall cycle (burst_resp=0) adds one cycle. There is no timeout.
- line_rdata holds its value until beats of the next read overwrite it. It is valid while line_resp=1 after a read.
- Writes never modify line_rdata.
- The 2-bit beat counter wraps to 0 only when leaving via DONE. It never wraps mid-burst.
- A request deasserted mid-burst is ignored: the burst completes and line_resp still pulses (no abort).
- burst_address and the latched wdata do not follow input changes during a burst.
- Reset mid-burst: on the next edge, state=IDLE and burst_read/burst_write=0. Partial line data is discarded, line_rdata=0, and no line_resp is issued.

Test Plan:
1. Read, zero-wait: line_read, line_address=0x0000_1234. Memory returns beats 0x0..0_A0, 0x0..0_A1, 0x0..0_A2, 0x0..0_A3 with burst_resp high cycles 1–4.
   -> burst_address=0x0000_1220 throughout; line_resp in cycle 5 only; line_rdata[63:0]=A0, [255:192]=A3.
2. Write with stalls: line_write, line_wdata beat i = 0x1111_1111_1111_1111*(i+1). burst_resp toggles 1,0,1,0,1,0,1.
   -> burst_wdata steps only after each resp; burst_write high 7 cycles; line_resp in cycle 8; line_rdata unchanged.
3. Simultaneous read and write held in IDLE.
   -> read burst first, line_resp, then write burst starts two cycles later; no overlap of burst_read and burst_write.
4. Request dropped after the first beat.
   -> remaining 3 beats still issued; single line_resp pulse.
5. rst_n=0 after 2 beats of a read.
   -> next edge: burst_read=0, line_rdata=0, no line_resp. A new read after rst_n=1 completes normally.
6. Back-to-back reads to 0x40 and 0x60, upstream re-requesting the cycle after line_resp.
   -> burst_address=0x40 then 0x60; second line_rdata fully replaces the first.
